// File: rtl/seed_g_arbiter.sv
// Two-requester arbiter in front of the shared SEED G-function unit, with a
// bounded R0 burst lock and a two-stage operand/result pipeline.
module seed_g_arbiter #(
  parameter int unsigned LOCK_MAX = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rstn,
  input  logic        i_Req0_Valid,
  input  logic [31:0] i_Req0_Data,
  input  logic        i_Req0_Lock,
  output logic        o_Req0_Ready,
  input  logic        i_Req1_Valid,
  input  logic [31:0] i_Req1_Data,
  output logic        o_Req1_Ready,
  output logic [31:0] o_G_Data,
  input  logic [31:0] i_G_Data,
  output logic [31:0] o_Rsp_Data,
  output logic        o_Rsp0_Valid,
  output logic        o_Rsp1_Valid,
  output logic        o_Busy
);

  localparam logic [3:0] LOCK_MAX_C = LOCK_MAX[3:0];

  logic [3:0]  lock_cnt_q, lock_cnt_d;
  logic        rr_q, rr_d;          // 1: R1 wins the next contested cycle
  logic [31:0] g_data_q, g_data_d;
  logic        a_vld_q, a_vld_d;
  logic        a_tag_q, a_tag_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp0_q, rsp0_d;
  logic        rsp1_q, rsp1_d;
  logic        grant0, grant1;
  logic        contested, locked, expiry;

  assign contested = i_Req0_Valid & i_Req1_Valid;
  assign locked    = (lock_cnt_q != 4'd0) && (lock_cnt_q < LOCK_MAX_C);

  // Grant selection: single valid wins, then lock, then round-robin.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!i_Rstn) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (contested) begin
      if (locked) begin
        grant0 = 1'b1;
      end else if (rr_q) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b1;
      end
    end else begin
      grant0 = i_Req0_Valid;
      grant1 = i_Req1_Valid;
    end
  end

  // Next-state for lock counter, round-robin pointer and both pipeline stages.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    expiry     = 1'b0;
    if (!i_Req0_Valid) begin
      lock_cnt_d = 4'd0;
    end else if (grant0) begin
      if (i_Req0_Lock) begin
        if (lock_cnt_q + 4'd1 == LOCK_MAX_C) begin
          lock_cnt_d = 4'd0;
          expiry     = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + 4'd1;
        end
      end else begin
        lock_cnt_d = 4'd0;
      end
    end else begin
      lock_cnt_d = lock_cnt_q;
    end

    rr_d = contested ? grant0 : rr_q;
    if (expiry) begin
      rr_d = 1'b1;
    end else begin
      rr_d = rr_d;
    end

    if (grant0) begin
      g_data_d = i_Req0_Data;
    end else if (grant1) begin
      g_data_d = i_Req1_Data;
    end else begin
      g_data_d = g_data_q;
    end
    a_vld_d = grant0 | grant1;
    a_tag_d = grant1;

    rsp_data_d = a_vld_q ? i_G_Data : rsp_data_q;
    rsp0_d     = a_vld_q & ~a_tag_q;
    rsp1_d     = a_vld_q & a_tag_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      lock_cnt_q <= 4'd0;
      rr_q       <= 1'b0;
      g_data_q   <= 32'd0;
      a_vld_q    <= 1'b0;
      a_tag_q    <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      rr_q       <= rr_d;
      g_data_q   <= g_data_d;
      a_vld_q    <= a_vld_d;
      a_tag_q    <= a_tag_d;
      rsp_data_q <= rsp_data_d;
      rsp0_q     <= rsp0_d;
      rsp1_q     <= rsp1_d;
    end
  end

  assign o_Req0_Ready = grant0;
  assign o_Req1_Ready = grant1;
  assign o_G_Data     = g_data_q;
  assign o_Rsp_Data   = rsp_data_q;
  assign o_Rsp0_Valid = rsp0_q;
  assign o_Rsp1_Valid = rsp1_q;
  assign o_Busy       = a_vld_q | rsp0_q | rsp1_q;

endmodule
